pe_network_interface: RTL and testbench

//  Network interface between a node's traffic source/sink and the router's local port (port 5).

---
 rtl/pe_nic_pkg.sv | 33 +++
 rtl/pe_flit_fifo.sv | 45 ++++
 rtl/pe_network_interface.sv | 112 +++++++++++
 tb/tb_pe_network_interface.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_nic_pkg.sv
// Flit layout, type codes and default widths shared by the PE network interface.
// Pure declarations: no latency, no backpressure.
package pe_nic_pkg;

    localparam int FLIT_W_DEF  = 20;
    localparam int POS_W_DEF   = 4;

    localparam int TYPE_LSB    = 18;
    localparam int TYPE_W      = 2;
    localparam int DEST_LSB    = 14;
    localparam int DEST_W      = 4;
    localparam int SRC_LSB     = 10;
    localparam int SRC_W       = 4;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_W   = 10;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    function automatic logic [FLIT_W_DEF-1:0] make_flit(
        input flit_type_e           ftype,
        input logic [DEST_W-1:0]    dest,
        input logic [SRC_W-1:0]     src,
        input logic [PAYLOAD_W-1:0] payload
    );
        return {ftype, dest, src, payload};
    endfunction

endpackage

// File: rtl/pe_flit_fifo.sv
// Synchronous flit FIFO: head visible the cycle after a push, pop advances on the edge.
// Backpressure via full; pushes while full and pops while empty are ignored.
module pe_flit_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/pe_network_interface.sv
// NIC beside router port 5: credit-controlled inject (push->inject_valid >= 2 cycles) and
// registered eject (1 cycle, never backpressured). PE_SRC_STAMP_EN stamps src with position.
module pe_network_interface
    import pe_nic_pkg::*;
#(
    parameter int FLIT_W     = FLIT_W_DEF,
    parameter int POS_W      = POS_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int CREDITS    = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [POS_W-1:0]  position,
    input  logic [FLIT_W-1:0] src_flit,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [FLIT_W-1:0] inject,
    output logic              inject_valid,
    input  logic              credit_in,
    input  logic [FLIT_W-1:0] eject,
    input  logic              eject_valid,
    output logic [FLIT_W-1:0] rx_flit,
    output logic              rx_valid,
    output logic              rx_dest_err,
    output logic              credit_err,
    output logic [2:0]        credit_count,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  rx_count
);

    localparam logic [2:0] CRED_MAX = 3'(CREDITS);

    logic              full;
    logic              empty;
    logic              push;
    logic              send;
    logic [FLIT_W-1:0] head;
    logic [FLIT_W-1:0] tx_flit;

    assign src_ready = !full;
    assign push      = src_valid && !full;
    assign send      = !empty && (credit_count != 3'd0);

    pe_flit_fifo #(
        .W     (FLIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (RST),
        .push     (push),
        .push_dat (src_flit),
        .pop      (send),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        tx_flit = head;
`ifdef PE_SRC_STAMP_EN
        tx_flit[SRC_LSB +: SRC_W] = SRC_W'(position);
`endif
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            inject       <= '0;
            inject_valid <= 1'b0;
            tx_count     <= '0;
        end else begin
            inject_valid <= send;
            if (send) begin
                inject   <= tx_flit;
                tx_count <= tx_count + 1'b1;
            end
        end
    end

    // A send and a returned credit in the same cycle cancel out.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            credit_count <= CRED_MAX;
            credit_err   <= 1'b0;
        end else if (send && !credit_in) begin
            credit_count <= credit_count - 3'd1;
        end else if (credit_in && !send) begin
            if (credit_count == CRED_MAX)
                credit_err <= 1'b1;
            else
                credit_count <= credit_count + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rx_flit     <= '0;
            rx_valid    <= 1'b0;
            rx_dest_err <= 1'b0;
            rx_count    <= '0;
        end else begin
            rx_valid <= eject_valid;
            if (eject_valid) begin
                rx_flit  <= eject;
                rx_count <= rx_count + 1'b1;
                if (eject[DEST_LSB +: DEST_W] != DEST_W'(position))
                    rx_dest_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_network_interface.sv
// Scoreboard bench for pe_network_interface: expected inject/eject flits are queued at stimulus
// time and a monitor compares them whenever inject_valid or rx_valid is seen.
module tb_pe_network_interface;
    import pe_nic_pkg::*;

    logic        clk = 1'b0;
    logic        RST;
    logic [3:0]  position;
    logic [19:0] src_flit;
    logic        src_valid;
    logic        src_ready;
    logic [19:0] inject;
    logic        inject_valid;
    logic        credit_in;
    logic [19:0] eject;
    logic        eject_valid;
    logic [19:0] rx_flit;
    logic        rx_valid;
    logic        rx_dest_err;
    logic        credit_err;
    logic [2:0]  credit_count;
    logic [15:0] tx_count;
    logic [15:0] rx_count;

    typedef struct {
        logic [19:0] flit;
        logic        dest_err;
    } rx_exp_t;

    logic [19:0] inj_q[$];
    rx_exp_t     rx_q[$];
    int          checks = 0;
    int          errors = 0;
    int          inj_seen = 0;

    pe_network_interface dut (
        .clk          (clk),
        .RST          (RST),
        .position     (position),
        .src_flit     (src_flit),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .inject       (inject),
        .inject_valid (inject_valid),
        .credit_in    (credit_in),
        .eject        (eject),
        .eject_valid  (eject_valid),
        .rx_flit      (rx_flit),
        .rx_valid     (rx_valid),
        .rx_dest_err  (rx_dest_err),
        .credit_err   (credit_err),
        .credit_count (credit_count),
        .tx_count     (tx_count),
        .rx_count     (rx_count)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] exp_inj(input logic [19:0] f);
        logic [19:0] r;
        r = f;
`ifdef PE_SRC_STAMP_EN
        r[13:10] = position;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_flit(input logic [19:0] f);
        int n;
        n = 0;
        src_flit  = f;
        src_valid = 1'b1;
        while (!src_ready && n < 50) begin
            tick();
            n++;
        end
        if (!src_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: src_ready stayed %0b, expected 1", src_ready);
        end
        inj_q.push_back(exp_inj(f));
        tick();
        src_valid = 1'b0;
    endtask

    task automatic credit_pulse();
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
    endtask

    // Monitor: compare every presented flit against the head of its expectation queue.
    always @(posedge clk) begin
        logic [19:0] e;
        rx_exp_t     r;
        #2;
        if (RST && inject_valid) begin
            inj_seen++;
            checks++;
            if (inj_q.size() == 0) begin
                errors++;
                $display("FAIL inject_unexpected: got %0h, expected no flit", inject);
            end else begin
                e = inj_q.pop_front();
                if (inject !== e) begin
                    errors++;
                    $display("FAIL inject_data: got %0h, expected %0h", inject, e);
                end
            end
        end
        if (RST && rx_valid) begin
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got %0h, expected no flit", rx_flit);
            end else begin
                r = rx_q.pop_front();
                if (rx_flit !== r.flit || rx_dest_err !== r.dest_err) begin
                    errors++;
                    $display("FAIL rx_data: got %0h err %0b, expected %0h err %0b",
                             rx_flit, rx_dest_err, r.flit, r.dest_err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        RST         = 1'b0;
        position    = 4'h5;
        src_flit    = '0;
        src_valid   = 1'b0;
        credit_in   = 1'b0;
        eject       = '0;
        eject_valid = 1'b0;
        tick();
        tick();
        check("rst_credit",   credit_count, 4);
        check("rst_inj_vld",  inject_valid, 0);
        check("rst_inject",   inject, 0);
        check("rst_tx",       tx_count, 0);
        RST = 1'b1;
        tick();
        check("rst_src_rdy",  src_ready, 1);

        // Three back-to-back pushes: inject_valid from 2 cycles after the first push.
        for (int i = 0; i < 3; i++) begin
            src_flit  = make_flit(FLIT_HEAD, 4'h3, 4'hF, 10'(16'h100 + i));
            src_valid = 1'b1;
            inj_q.push_back(exp_inj(src_flit));
            tick();
            check("t2_inj_vld", inject_valid, (i == 0) ? 0 : 1);
        end
        src_valid = 1'b0;
        tick();
        check("t2_inj_vld3",  inject_valid, 1);
        tick();
        check("t2_inj_off",   inject_valid, 0);
        check("t2_credit",    credit_count, 1);
        check("t2_tx",        tx_count, 3);
        for (int i = 0; i < 3; i++) credit_pulse();
        check("t2_refill",    credit_count, 4);

        // Six pushes, no credits returned: four go, two wait.
        base = inj_seen;
        for (int i = 0; i < 6; i++) send_flit(make_flit(FLIT_BODY, 4'h2, 4'h1, 10'(16'h200 + i)));
        for (int i = 0; i < 6; i++) tick();
        check("t3_sent4",     inj_seen - base, 4);
        check("t3_credit0",   credit_count, 0);
        check("t3_stall",     inject_valid, 0);
        credit_in = 1'b1;
        tick();
        check("t3_cr_lat1",   inject_valid, 0);
        credit_in = 1'b0;
        tick();
        check("t3_cr_lat2",   inject_valid, 1);
        check("t3_tx",        tx_count, 8);
        credit_pulse();
        tick();
        tick();
        check("t3_tx_drain",  tx_count, 9);

        // Fill the FIFO with credits at zero.
        for (int i = 0; i < 8; i++) send_flit(make_flit(FLIT_TAIL, 4'h7, 4'h2, 10'(16'h300 + i)));
        check("t4_full",      src_ready, 0);
        src_flit  = make_flit(FLIT_SINGLE, 4'h7, 4'h2, 10'h3FF);
        src_valid = 1'b1;
        tick();
        tick();
        check("t4_hold",      src_ready, 0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("t4_not_popped", src_ready, 0);
        tick();
        check("t4_slot_free", src_ready, 1);
        inj_q.push_back(exp_inj(src_flit));
        tick();
        src_valid = 1'b0;
        check("t4_full_again", src_ready, 0);
        credit_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        credit_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t4_drained",   inj_q.size(), 0);
        check("t4_credit0",   credit_count, 0);
        check("t4_tx",        tx_count, 18);

        // Simultaneous send and credit return, then overflow.
        credit_in = 1'b1;
        tick();
        tick();
        credit_in = 1'b0;
        check("t5_credit2",   credit_count, 2);
        send_flit(make_flit(FLIT_SINGLE, 4'h1, 4'hF, 10'h155));
        check("t5_pre",       credit_count, 2);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("t5_both",      credit_count, 2);
        check("t5_inj_vld",   inject_valid, 1);
        credit_pulse();
        credit_pulse();
        check("t5_credit4",   credit_count, 4);
        check("t5_no_err",    credit_err, 0);
        credit_pulse();
        check("t5_err",       credit_err, 1);
        check("t5_sat",       credit_count, 4);
        check("t5_tx",        tx_count, 19);

        // Eject path at position 5.
        eject       = make_flit(FLIT_HEAD, 4'h5, 4'h9, 10'h0AA);
        eject_valid = 1'b1;
        rx_q.push_back('{flit: eject, dest_err: 1'b0});
        tick();
        check("t6_rx_lat",    rx_valid, 1);
        check("t6_err_pre",   rx_dest_err, 0);
        eject = make_flit(FLIT_TAIL, 4'h3, 4'h9, 10'h0BB);
        rx_q.push_back('{flit: eject, dest_err: 1'b1});
        tick();
        eject_valid = 1'b0;
        check("t6_err_post",  rx_dest_err, 1);
        tick();
        check("t6_rx_off",    rx_valid, 0);
        check("t6_rx_count",  rx_count, 2);
        check("t6_rx_hold",   rx_flit, make_flit(FLIT_TAIL, 4'h3, 4'h9, 10'h0BB));
        check("t6_q_empty",   rx_q.size(), 0);

        // Reset in the middle of traffic.
        send_flit(make_flit(FLIT_HEAD, 4'h4, 4'h5, 10'h011));
        send_flit(make_flit(FLIT_BODY, 4'h4, 4'h5, 10'h022));
        RST = 1'b0;
        inj_q.delete();
        tick();
        check("t1_credit",    credit_count, 4);
        check("t1_src_rdy",   src_ready, 1);
        check("t1_inj_vld",   inject_valid, 0);
        check("t1_tx",        tx_count, 0);
        check("t1_rx",        rx_count, 0);
        check("t1_cerr",      credit_err, 0);
        check("t1_derr",      rx_dest_err, 0);
        RST = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t1_fifo_drop", tx_count, 0);
        check("t1_q_empty",   inj_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
